// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Serial input line and parallel byte output bundle of the
//               8N1 UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_rx_if;
  logic       i_rx;         // serial line, idle high
  logic [7:0] o_data;       // last correctly framed byte
  logic       o_valid;      // one-cycle strobe when o_data updates
  logic       o_frame_err;  // one-cycle strobe on a low stop bit
  logic       o_busy;       // receiver is not idle

  // Receiver side
  modport slave (
    input  i_rx,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  // Line driver / byte consumer side
  modport master (
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with a 2-flop input synchronizer, start-bit
//               glitch rejection and stop-bit framing check. Bit time is
//               TICKS_PER_BIT clock cycles; all samples land mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx #(
  parameter int TICKS_PER_BIT      = 868,
  parameter int TICKS_PER_BIT_SIZE = 10
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst,
  uart_rx_if.slave   rx_bus
);

  // Terminal counts: half a bit for the start sample, a full bit afterwards
  localparam logic [TICKS_PER_BIT_SIZE-1:0] c_half_m1 =
    TICKS_PER_BIT_SIZE'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TICKS_PER_BIT_SIZE-1:0] c_bit_m1 =
    TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_START   = 5'b00010,
    S_DATA    = 5'b00100,
    S_STOP    = 5'b01000,
    S_RECOVER = 5'b10000
  } state_t;

  state_t                        r_state;
  logic                          r_rx_meta;
  logic                          r_rx_s;
  logic [TICKS_PER_BIT_SIZE-1:0] r_tick;
  logic [3:0]                    r_bit_cnt;
  logic [7:0]                    r_shift;
  logic [7:0]                    r_data;
  logic                          r_valid;
  logic                          r_frame_err;
  logic                          r_busy;

  // Two-flop synchronizer; idle-high reset so reset never looks like a start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_bus.i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Frame state machine with registered strobes and busy flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_tick == c_half_m1) begin
            r_tick <= '0;
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 4'd0;
            end else begin
              // Line went back high before mid start bit: treat as noise
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_DATA: begin
          if (r_tick == c_bit_m1) begin
            r_tick    <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_STOP: begin
          if (r_tick == c_bit_m1) begin
            r_tick <= '0;
            if (r_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_RECOVER;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_RECOVER: begin
          // Hold off until the line idles so a long break reports only once
          r_tick <= '0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.o_data      = r_data;
  assign rx_bus.o_valid     = r_valid;
  assign rx_bus.o_frame_err = r_frame_err;
  assign rx_bus.o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at TICKS_PER_BIT=16. A line
//               driver pushes the expected strobe (kind, data, cycle) into a
//               queue; an independent monitor pops and compares on each
//               o_valid / o_frame_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int T   = 16;
  localparam int H   = T / 2;
  localparam int LAT = 2 + H + 9 * T;  // edge E to the strobe cycle

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    longint      cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cycle = 0;
  int     total = 0;
  int     bad = 0;
  int     n_valid = 0;
  int     n_ferr = 0;
  logic [7:0] last_data = 8'h00;
  exp_t   q[$];
  exp_t   mon_e;

  uart_rx_if bus ();

  uart_rx #(
    .TICKS_PER_BIT      (T),
    .TICKS_PER_BIT_SIZE (5)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .rx_bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard monitor: every strobe must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) n_valid++;
      if (bus.o_frame_err) n_ferr++;
      if (bus.o_valid || bus.o_frame_err) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%02h cycle=%0d, none expected",
                   bus.o_valid, bus.o_frame_err, bus.o_data, cycle);
        end else begin
          mon_e = q.pop_front();
          if (bus.o_frame_err !== mon_e.is_err || bus.o_valid !== !mon_e.is_err ||
              bus.o_data !== mon_e.data || cycle != mon_e.cyc ||
              bus.o_busy !== mon_e.is_err) begin
            bad++;
            $display("FAIL strobe: got valid=%0b ferr=%0b data=%02h busy=%0b cycle=%0d; required err=%0b data=%02h busy=%0b cycle=%0d",
                     bus.o_valid, bus.o_frame_err, bus.o_data, bus.o_busy, cycle,
                     mon_e.is_err, mon_e.data, mon_e.is_err, mon_e.cyc);
          end
        end
      end else if (q.size() > 0 && cycle > q[0].cyc) begin
        total++;
        bad++;
        mon_e = q.pop_front();
        $display("FAIL missed_strobe: nothing by cycle %0d, required err=%0b data=%02h at cycle %0d",
                 cycle, mon_e.is_err, mon_e.data, mon_e.cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Hold the line at b for n clock edges; returns 1 time unit after an edge
  task automatic drive_bit(input logic b, input int n);
    bus.i_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one 8N1 frame and queue the strobe it must produce
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    exp_t e;
    e.cyc    = cycle + 1 + LAT;
    e.is_err = !stop_bit;
    e.data   = stop_bit ? d : last_data;
    q.push_back(e);
    if (stop_bit) last_data = d;
    drive_bit(1'b0, T);
    for (int i = 0; i < 8; i++) drive_bit(d[i], T);
    drive_bit(stop_bit, T);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'h0, bus.o_data}, 32'h00);
    check({tag, "_valid"}, {31'h0, bus.o_valid}, 32'h0);
    check({tag, "_ferr"},  {31'h0, bus.o_frame_err}, 32'h0);
    check({tag, "_busy"},  {31'h0, bus.o_busy}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int f0;
    bus.i_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    drive_bit(1'b1, 5);

    // Single byte 0xA5 with busy timing around the frame
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (2) @(posedge clk);  // E+1
        #1 check("a5_busy_e1", {31'h0, bus.o_busy}, 32'h0);
        @(posedge clk);             // E+2
        #1 check("a5_busy_e2", {31'h0, bus.o_busy}, 32'h1);
        repeat (151) @(posedge clk); // E+153
        #1 check("a5_busy_e153", {31'h0, bus.o_busy}, 32'h1);
        @(posedge clk);             // E+154
        #1 check("a5_busy_e154", {31'h0, bus.o_busy}, 32'h0);
      end
    join
    drive_bit(1'b1, 10);
    check("a5_held", {24'h0, bus.o_data}, 32'hA5);

    // Glitch: low for 4 cycles; busy high only for E+2 .. E+2+H-1
    v0 = n_valid;
    f0 = n_ferr;
    bus.i_rx = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) bus.i_rx = 1'b1;
      check($sformatf("glitch_busy_k%0d", k), {31'h0, bus.o_busy},
            {31'h0, (k >= 3 && k <= 2 + H)});
    end
    drive_bit(1'b1, 10);
    check("glitch_no_valid", n_valid - v0, 32'h0);
    check("glitch_no_ferr", n_ferr - f0, 32'h0);
    check("glitch_data", {24'h0, bus.o_data}, 32'hA5);

    // Framing error: 0x3C with a low stop bit, then 40 more low cycles
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 40);
    check("ferr_busy_low_line", {31'h0, bus.o_busy}, 32'h1);
    bus.i_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("ferr_busy_plus2", {31'h0, bus.o_busy}, 32'h1);
    @(posedge clk);
    #1 check("ferr_busy_plus3", {31'h0, bus.o_busy}, 32'h0);
    drive_bit(1'b1, 10);
    check("ferr_data_kept", {24'h0, bus.o_data}, 32'hA5);

    // Back-to-back 0x00 then 0xFF, no idle gap (strobes 160 cycles apart)
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, 10);
    check("b2b_last", {24'h0, bus.o_data}, 32'hFF);

    // Reset in the middle of bit 3 of 0x5A
    drive_bit(1'b0, T);
    drive_bit(1'b0, T);  // bit0
    drive_bit(1'b1, T);  // bit1
    drive_bit(1'b0, T);  // bit2
    drive_bit(1'b1, H);  // half of bit3
    #2 rst = 1'b1;
    #2 check_reset_outputs("midrst");
    bus.i_rx = 1'b1;
    last_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midrst_hold");
    rst = 1'b0;
    drive_bit(1'b1, 5);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 10);
    check("after_rst_data", {24'h0, bus.o_data}, 32'h81);

    // Loopback stream of all 256 byte values, back-to-back
    v0 = n_valid;
    f0 = n_ferr;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
    drive_bit(1'b1, 20);
    check("loop_valid_count", n_valid - v0, 32'd256);
    check("loop_ferr_count", n_ferr - f0, 32'd0);
    check("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver that turns the serial line driven by the team's UART transmitter (or an external host) back into parallel bytes. It sits at the chip's serial input and hands each received byte to downstream logic with a one-cycle valid strobe. Bit timing is set by a clock-tick count per bit, so it runs at the same baud rate as the transmitter when given the same parameter values. It also includes:

- a 2-flop input synchronizer;
- start-bit glitch rejection;
- stop-bit (framing) checking.

## Interface

Parameters:

- `TICKS_PER_BIT`, default 868: `i_clk` cycles per serial bit (T). Must be ≥ 4.
- `TICKS_PER_BIT_SIZE`, default 10: width of the tick counter. Must satisfy 2^size > `TICKS_PER_BIT`-1.

Ports:

- `i_clk`, input, 1: the single clock. All logic is rising-edge.
- `i_rst`, input, 1: asynchronous reset, active-high.
- `i_rx`, input, 1: serial line, idle high. Asynchronous to `i_clk`.
- `o_data`, output, 8: last correctly framed byte. Holds its value until the next good frame.
- `o_valid`, output, 1: one-cycle pulse when `o_data` is updated.
- `o_frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `o_busy`, output, 1: high in every state except IDLE.

## Operation

- Synchronizer:
  - Two flops, `rx_s` = stage 2; both reset to 1.
  - All decisions use `rx_s` only.
- Counters, all reset to 0:
  - Tick counter, width `TICKS_PER_BIT_SIZE`.
  - Bit counter, 4 bits.
  - Shift register, 8 bits.
- Let H = `TICKS_PER_BIT`/2, using integer division.
- State machine, one-hot, reset to IDLE:
  - IDLE: tick counter held at 0. If `rx_s`=0, go to START.
  - START: tick counter increments. At count H-1, sample `rx_s`:
    - 0: go to DATA, clearing the tick counter and bit counter.
    - 1: glitch; go back to IDLE with no output pulse.
  - DATA: tick counter counts 0..T-1 and wraps. At count T-1:
    - Shift `rx_s` into the shift register MSB, shifting right (line is LSB first).
    - Increment the bit counter.
    - When the 8th bit has been sampled (bit counter reaches 8), go to STOP with the tick counter cleared.
  - STOP: at count T-1, sample `rx_s`:
    - 1: `o_data` <= shift register, pulse `o_valid`, go to IDLE.
    - 0: pulse `o_frame_err`, leave `o_data` unchanged, go to RECOVER.
  - RECOVER: wait for `rx_s`=1 (line idle or break end), then go to IDLE. A held-low break produces exactly one `o_frame_err`.
- Sampling points:
  - Every sample falls mid-bit: START lasts H cycles, each later bit T cycles.
  - STOP exits at mid stop bit, leaving half a bit of margin to resynchronize on a back-to-back start edge.
- Unsupported: parity, oversampling voting, FIFO buffering. Downstream must consume the byte within one frame time.

## Timing

- Reset values: `o_data`=0x00, `o_valid`=0, `o_frame_err`=0, `o_busy`=0, state IDLE.
- Reset is asynchronous and may arrive at any point. If asserted mid-frame, everything returns to reset values immediately and no pulse is emitted. After release, the receiver waits for a fresh falling edge; a line already low at release is treated as a start.
- Latency, with edge E being the first edge at which `i_rx` is captured low by sync stage 1:
  - START is entered at E+2.
  - DATA is entered at E+2+H.
  - STOP is entered at E+2+H+8T.
  - `o_valid` (or `o_frame_err`) is high for exactly the one cycle after edge E+2+H+9T.
  - At the defaults this is E+8248.
- `o_valid` and `o_frame_err` are never high together. Both are registered.
- `o_busy` rises at E+2 and falls on the same edge that raises `o_valid`. Framing error path: `o_busy` falls on the edge that leaves RECOVER.
- Next frame: a start edge arriving while the stop bit is still high is missed only if it lands before STOP exits. The transmitter always sends a full stop bit, which guarantees it is caught.
- No flow control: a second frame overwrites `o_data` regardless of the consumer.

## Test plan

Use `TICKS_PER_BIT`=16 (H=8) unless stated otherwise.

- Single byte 0xA5, ideal timing. Required response:
  - `o_valid` high for 1 cycle at E+154.
  - `o_data`=0xA5 and held.
  - `o_busy` high from E+2 through E+154.
  - `o_frame_err` stays 0.
- Glitch: `i_rx` low for 4 cycles, then high. Required response:
  - `o_busy` pulses for H cycles, then returns to 0.
  - No `o_valid` or `o_frame_err`; `o_data` unchanged.
- Framing error: byte 0x3C with the stop bit driven 0 and the line held low 40 more cycles. Required response:
  - One `o_frame_err` pulse at E+154.
  - `o_data` keeps its previous value.
  - `o_busy` stays high until 2 cycles after the line returns high, then falls.
- Back-to-back frames 0x00 then 0xFF, each with a 1-bit stop and no idle gap. Required response:
  - Two `o_valid` pulses, 160 cycles apart.
  - `o_data` reads 0x00, then 0xFF.
- Reset mid-frame: assert `i_rst` during bit 3 of 0x5A, release, then send 0x81. Required response:
  - All outputs are at reset values during reset.
  - 0x5A is never reported.
  - 0x81 is received correctly.
- Loopback with the team transmitter at default parameters, 256 bytes 0x00..0xFF. Required response:
  - Every byte is received in order.
  - 256 `o_valid` pulses, 0 framing errors.
